// File: rtl/ripple_adder_64_if.sv
// ============================================================================
// ripple_adder_64_if : operand/result bundle for ripple_adder_64 (rev 1.0)
// ============================================================================
`default_nettype none

interface ripple_adder_64_if #(
   parameter int WIDTH = 64
);
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   modport master (
      output in1, in2, cin,
      input  sum, cout, sum_q, cout_q
   );

   modport slave (
      input  in1, in2, cin,
      output sum, cout, sum_q, cout_q
   );
endinterface

`default_nettype wire

// File: rtl/ripple_adder_64.sv
// ============================================================================
// ripple_adder_64 : WIDTH-bit ripple-carry adder, combinational + registered
// rev 1.0
// ============================================================================
`default_nettype none

module ripple_adder_64 #(
   parameter int WIDTH = 64
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   ripple_adder_64_if.slave    bus_io
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   assign w_carry[0] = bus_io.cin;

   // Gate-level cells keep X/Z propagation faithful to each bit's inputs.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_fa
         logic w_p;
         assign w_p          = bus_io.in1[i] ^ bus_io.in2[i];
         assign w_sum[i]     = w_p ^ w_carry[i];
         assign w_carry[i+1] = (bus_io.in1[i] & bus_io.in2[i]) | (w_carry[i] & w_p);
      end
   endgenerate

   assign bus_io.sum  = w_sum;
   assign bus_io.cout = w_carry[WIDTH];

   assign sum_d  = w_sum;
   assign cout_d = w_carry[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign bus_io.sum_q  = sum_q;
   assign bus_io.cout_q = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_ripple_adder_64.sv
// ============================================================================
// tb_ripple_adder_64 : directed-vector self-checking bench for ripple_adder_64
// ============================================================================
`default_nettype none

module tb_ripple_adder_64;

   localparam int WIDTH = 64;
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   ripple_adder_64_if #(.WIDTH(WIDTH)) bus ();

   ripple_adder_64 #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
      bus.in1 = a;
      bus.in2 = b;
      bus.cin = c;
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_vec(64'd5, 64'd7, 1'b0);
      checks++;
      if (bus.sum_q !== '0) begin
         errors++;
         $display("FAIL reset_sum_q: got %h expected %h", bus.sum_q, {WIDTH{1'b0}});
      end
      checks++;
      if (bus.cout_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_cout_q: got %b expected 0", bus.cout_q);
      end
      checks++;
      if (bus.sum !== 64'd12 || bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL comb_in_reset: got %h/%b expected 000000000000000c/0", bus.sum, bus.cout);
      end
   endtask

   task automatic test_zero();
      drive_vec(64'd0, 64'd0, 1'b0);
      checks++;
      if (bus.sum !== 64'd0) begin
         errors++;
         $display("FAIL zero_sum: got %h expected 0", bus.sum);
      end
      checks++;
      if (bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL zero_cout: got %b expected 0", bus.cout);
      end
   endtask

   task automatic test_small();
      drive_vec(64'd1, 64'd1, 1'b1);
      checks++;
      if (bus.sum !== 64'h3) begin
         errors++;
         $display("FAIL small_sum: got %h expected 3", bus.sum);
      end
      checks++;
      if (bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL small_cout: got %b expected 0", bus.cout);
      end
   endtask

   task automatic test_full_ripple();
      drive_vec(ONES, 64'd1, 1'b0);
      checks++;
      if (bus.sum !== 64'd0 || bus.cout !== 1'b1) begin
         errors++;
         $display("FAIL ripple_cin0: got %h/%b expected 0/1", bus.sum, bus.cout);
      end
      drive_vec(ONES, 64'd1, 1'b1);
      checks++;
      if (bus.sum !== 64'd1) begin
         errors++;
         $display("FAIL ripple_cin1_sum: got %h expected 1", bus.sum);
      end
      checks++;
      if (bus.cout !== 1'b1) begin
         errors++;
         $display("FAIL ripple_cin1_cout: got %b expected 1", bus.cout);
      end
   endtask

   task automatic test_max();
      drive_vec(ONES, ONES, 1'b0);
      checks++;
      if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFFE || bus.cout !== 1'b1) begin
         errors++;
         $display("FAIL max_cin0: got %h/%b expected fffffffffffffffe/1", bus.sum, bus.cout);
      end
      drive_vec(ONES, ONES, 1'b1);
      checks++;
      if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFFF || bus.cout !== 1'b1) begin
         errors++;
         $display("FAIL max_cin1: got %h/%b expected ffffffffffffffff/1", bus.sum, bus.cout);
      end
   endtask

   task automatic test_alternating();
      drive_vec(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
      checks++;
      if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFFF || bus.cout !== 1'b0) begin
         errors++;
         $display("FAIL alt_cin0: got %h/%b expected ffffffffffffffff/0", bus.sum, bus.cout);
      end
      drive_vec(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
      checks++;
      if (bus.sum !== 64'd0 || bus.cout !== 1'b1) begin
         errors++;
         $display("FAIL alt_cin1: got %h/%b expected 0/1", bus.sum, bus.cout);
      end
   endtask

   task automatic test_registered();
      // Load a non-zero value so the asynchronous clear is observable.
      @(negedge clk);
      rst_n = 1'b1;
      drive_vec(ONES, ONES, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if (bus.sum_q !== ONES || bus.cout_q !== 1'b1) begin
         errors++;
         $display("FAIL reg_preload: got %h/%b expected ffffffffffffffff/1", bus.sum_q, bus.cout_q);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.sum_q !== '0 || bus.cout_q !== 1'b0) begin
         errors++;
         $display("FAIL reg_async_clear: got %h/%b expected 0/0", bus.sum_q, bus.cout_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_vec(ONES, ONES, 1'b0);
      checks++;
      if (bus.sum_q !== '0 || bus.cout_q !== 1'b0) begin
         errors++;
         $display("FAIL reg_hold_before_edge: got %h/%b expected 0/0", bus.sum_q, bus.cout_q);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.sum_q !== 64'hFFFF_FFFF_FFFF_FFFE || bus.cout_q !== 1'b1) begin
         errors++;
         $display("FAIL reg_capture_max: got %h/%b expected fffffffffffffffe/1", bus.sum_q, bus.cout_q);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      drive_vec(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
      @(negedge clk);
      drive_vec(64'd1, 64'd1, 1'b1);
      checks++;
      if (bus.sum_q !== 64'd0 || bus.cout_q !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: got %h/%b expected 0/1", bus.sum_q, bus.cout_q);
      end
      @(negedge clk);
      checks++;
      if (bus.sum_q !== 64'h3 || bus.cout_q !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got %h/%b expected 3/0", bus.sum_q, bus.cout_q);
      end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      rst_n   = 1'b0;
      bus.in1 = '0;
      bus.in2 = '0;
      bus.cin = 1'b0;
      test_reset();
      test_zero();
      test_small();
      test_full_ripple();
      test_max();
      test_alternating();
      test_registered();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
